// File: rtl/rv_rf_pkg.sv
//==============================================================================
// Module : rv_rf_pkg
// Brief  : Shared constants, FSM state type and helpers for the register-file
//          writeback controller.
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package rv_rf_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Highest architectural register; the clear sequence ends here.
  localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

  // Controller modes: sequential clear of x1..x31, then arbitrated writeback.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_rr_arb.sv
//==============================================================================
// Module : rv_rr_arb
// Brief  : Combinational round-robin arbiter. Search starts one slot after the
//          pointer (the last granted index) and wraps; grant is one-hot or zero.
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module rv_rr_arb #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  int               pos;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk the requesters in circular order after ptr; first asserted one wins.
  always_comb begin
    gnt   = '0;
    pos   = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      idx = pos[PTR_W-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv_rf_wr_ctrl.sv
//==============================================================================
// Module : rv_rf_wr_ctrl
// Brief  : Register-file write controller. After reset (or an init request)
//          it clears x1..x31 one register per cycle, then arbitrates writeback
//          requests round-robin and drives a registered write port.
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module rv_rf_wr_ctrl
  import rv_rf_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init_req_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]   req_rd_addr_i,
  input  logic [NUM_REQ*XLEN-1:0]         req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            rf_wr_en_o,
  output logic [REG_ADDR_W-1:0]           rf_rd_addr_o,
  output logic [XLEN-1:0]                 rf_wr_data_o,
  output logic                            init_done_o
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam logic [PTR_W-1:0]      PTR_RST   = PTR_W'(NUM_REQ - 1);
  localparam logic [REG_ADDR_W-1:0] FIRST_REG = REG_ADDR_W'(1);

  rf_state_t             state;
  logic [REG_ADDR_W-1:0] cnt;
  logic [PTR_W-1:0]      rr_ptr;

  logic [NUM_REQ-1:0]    grant;
  logic                  xfer;
  logic [PTR_W-1:0]      grant_idx;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]       sel_data;

  rv_rr_arb #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req_valid_i),
    .ptr (rr_ptr),
    .gnt (grant)
  );

  // Grants only reach requesters in RUN, and an init request blocks them so
  // no transfer is lost across the switch back to INIT.
  assign req_ready_o = ((state == RUN) && !init_req_i) ? grant : '0;
  assign xfer        = |req_ready_o;

  // Steer the granted requester's address, data and index onto the write path.
  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req_ready_o[j]) begin
        grant_idx = PTR_W'(j);
        sel_addr  = req_rd_addr_i[j*REG_ADDR_W +: REG_ADDR_W];
        sel_data  = req_data_i[j*XLEN +: XLEN];
      end
    end
  end

  // Mode FSM with registered write port: clear sweep in INIT, arbitrated
  // writeback in RUN. Writes to x0 are accepted but never enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= INIT;
      cnt          <= FIRST_REG;
      rr_ptr       <= PTR_RST;
      rf_wr_en_o   <= 1'b0;
      rf_rd_addr_o <= '0;
      rf_wr_data_o <= '0;
      init_done_o  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          rf_wr_en_o   <= 1'b1;
          rf_rd_addr_o <= cnt;
          rf_wr_data_o <= '0;
          if (cnt == LAST_REG) begin
            state       <= RUN;
            cnt         <= FIRST_REG;
            init_done_o <= 1'b1;
          end else begin
            cnt <= cnt + REG_ADDR_W'(1);
          end
        end
        RUN: begin
          if (xfer) begin
            rf_wr_en_o   <= (sel_addr != '0);
            rf_rd_addr_o <= sel_addr;
            rf_wr_data_o <= sel_data;
            rr_ptr       <= grant_idx;
          end else begin
            rf_wr_en_o <= 1'b0;
          end
          if (init_req_i) begin
            state       <= INIT;
            cnt         <= FIRST_REG;
            init_done_o <= 1'b0;
          end
        end
        default: begin
          state       <= INIT;
          cnt         <= FIRST_REG;
          rf_wr_en_o  <= 1'b0;
          init_done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_rf_wr_ctrl.sv
//==============================================================================
// Module : tb_rv_rf_wr_ctrl
// Brief  : Self-checking bench for rv_rf_wr_ctrl with a behavioural model of
//          the clear sequence and round-robin writeback.
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rv_rf_wr_ctrl;

  logic        clk;
  logic        reset;
  logic        init_req;
  logic [2:0]  valid;
  logic [4:0]  addr [0:2];
  logic [31:0] data [0:2];
  logic [14:0] addr_flat;
  logic [95:0] data_flat;
  logic [2:0]  ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        done;

  int n_cmp;
  int n_err;

  // Behavioural model state
  bit          m_init;
  int          m_cnt;
  int          m_ptr;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_done;

  assign addr_flat = {addr[2], addr[1], addr[0]};
  assign data_flat = {data[2], data[1], data[0]};

  rv_rf_wr_ctrl #(.NUM_REQ(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .init_req_i    (init_req),
    .req_valid_i   (valid),
    .req_rd_addr_i (addr_flat),
    .req_data_i    (data_flat),
    .req_ready_o   (ready),
    .rf_wr_en_o    (wr_en),
    .rf_rd_addr_o  (wr_addr),
    .rf_wr_data_o  (wr_data),
    .init_done_o   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_init = 1'b1;
    m_cnt  = 1;
    m_ptr  = 2;
    m_en   = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_done = 1'b0;
  endfunction

  // Expected grant: first valid requester after the last granted one.
  function automatic logic [2:0] model_ready();
    logic [2:0] r;
    int i;
    r = '0;
    if (m_init || init_req) return r;
    for (int k = 1; k <= 3; k++) begin
      i = (m_ptr + k) % 3;
      if (valid[i[1:0]]) begin
        r[i[1:0]] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void model_clock();
    logic [2:0] r;
    r = model_ready();
    if (m_init) begin
      m_en   = 1'b1;
      m_addr = m_cnt[4:0];
      m_data = '0;
      if (m_cnt == 31) begin
        m_init = 1'b0;
        m_done = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      m_en = 1'b0;
      for (int g = 0; g < 3; g++) begin
        if (r[g]) begin
          m_en   = (addr[g] != 5'd0);
          m_addr = addr[g];
          m_data = data[g];
          m_ptr  = g;
        end
      end
      if (init_req) begin
        m_init = 1'b1;
        m_done = 1'b0;
        m_cnt  = 1;
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (wr_en !== 1'b0)   begin n_err++; $display("FAIL reset_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", wr_addr); end
    n_cmp++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", wr_data); end
    n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 31; k++) begin
      #1;
      n_cmp++; if (ready !== 3'b000) begin n_err++; $display("FAIL clear_ready[%0d]: got %b want 000", k, ready); end
      model_clock();
      @(posedge clk); #1;
      n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL clear_en[%0d]: got %b want 1", k, wr_en); end
      n_cmp++; if (wr_addr !== k[4:0]) begin n_err++; $display("FAIL clear_addr[%0d]: got %0d want %0d", k, wr_addr, k); end
      n_cmp++; if (wr_data !== 32'd0) begin n_err++; $display("FAIL clear_data[%0d]: got %h want 0", k, wr_data); end
      n_cmp++; if (done !== (k == 31)) begin n_err++; $display("FAIL clear_done[%0d]: got %b want %b", k, done, (k == 31)); end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] want;
    valid   = 3'b111;
    addr[0] = 5'd5; addr[1] = 5'd6; addr[2] = 5'd7;
    for (int i = 0; i < 3; i++) data[i] = $urandom;
    for (int c = 0; c < 9; c++) begin
      #1;
      want = 3'b001 << (c % 3);
      n_cmp++; if (ready !== want) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", c, ready, want); end
      model_clock();
      @(posedge clk); #1;
      n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL rr_en[%0d]: got %b want 1", c, wr_en); end
      n_cmp++; if (wr_addr !== 5'(5 + c % 3)) begin n_err++; $display("FAIL rr_addr[%0d]: got %0d want %0d", c, wr_addr, 5 + c % 3); end
      n_cmp++; if (wr_data !== m_data) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", c, wr_data, m_data); end
      @(negedge clk);
      data[c % 3] = $urandom;
    end
    valid = 3'b000;
  endtask

  task automatic test_x0_write();
    valid   = 3'b010;
    addr[1] = 5'd0;
    data[1] = 32'hDEADBEEF;
    #1;
    n_cmp++; if (ready !== 3'b010) begin n_err++; $display("FAIL x0_ready: got %b want 010", ready); end
    model_clock();
    @(posedge clk); #1;
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL x0_en: got %b want 0", wr_en); end
    @(negedge clk);
    valid = 3'b000;
  endtask

  task automatic test_x9_write();
    valid   = 3'b100;
    addr[2] = 5'd9;
    data[2] = 32'h12345678;
    #1;
    n_cmp++; if (ready !== 3'b100) begin n_err++; $display("FAIL x9_ready: got %b want 100", ready); end
    model_clock();
    @(posedge clk); #1;
    n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL x9_en: got %b want 1", wr_en); end
    n_cmp++; if (wr_addr !== 5'd9) begin n_err++; $display("FAIL x9_addr: got %0d want 9", wr_addr); end
    n_cmp++; if (wr_data !== 32'h12345678) begin n_err++; $display("FAIL x9_data: got %h want 12345678", wr_data); end
    @(negedge clk);
    valid = 3'b000;
    #1;
    model_clock();
    @(posedge clk); #1;
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL idle_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== 5'd9) begin n_err++; $display("FAIL idle_addr_hold: got %0d want 9", wr_addr); end
    n_cmp++; if (wr_data !== 32'h12345678) begin n_err++; $display("FAIL idle_data_hold: got %h want 12345678", wr_data); end
    @(negedge clk);
  endtask

  task automatic test_init_req();
    valid   = 3'b001;
    addr[0] = 5'd17;
    data[0] = 32'hA5A5_0001;
    #1;
    n_cmp++; if (ready !== 3'b001) begin n_err++; $display("FAIL pre_init_ready: got %b want 001", ready); end
    model_clock();
    @(negedge clk);
    // Transfer from the previous cycle must be on the port; now request init.
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd17) begin n_err++; $display("FAIL pre_init_write: got en=%b addr=%0d want en=1 addr=17", wr_en, wr_addr); end
    data[0]  = 32'hA5A5_0002;
    init_req = 1'b1;
    #1;
    n_cmp++; if (ready !== 3'b000) begin n_err++; $display("FAIL init_req_ready: got %b want 000", ready); end
    model_clock();
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL init_req_done: got %b want 0", done); end
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL init_req_en: got %b want 0", wr_en); end
    @(negedge clk);
    init_req = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      #1;
      n_cmp++; if (ready !== 3'b000) begin n_err++; $display("FAIL reclear_ready[%0d]: got %b want 000", k, ready); end
      model_clock();
      @(posedge clk); #1;
      n_cmp++; if (wr_en !== 1'b1 || wr_addr !== k[4:0] || wr_data !== 32'd0) begin
        n_err++; $display("FAIL reclear_write[%0d]: got en=%b addr=%0d data=%h want en=1 addr=%0d data=0", k, wr_en, wr_addr, wr_data, k);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (ready !== 3'b001) begin n_err++; $display("FAIL first_run_ready: got %b want 001", ready); end
    model_clock();
    @(posedge clk); #1;
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd17 || wr_data !== 32'hA5A5_0002) begin
      n_err++; $display("FAIL first_run_write: got en=%b addr=%0d data=%h want en=1 addr=17 data=a5a50002", wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
    valid = 3'b000;
  endtask

  task automatic test_random();
    logic [2:0] exp_ready;
    for (int i = 0; i < 3; i++) begin
      valid[i] = ($urandom_range(0, 9) < 6);
      addr[i]  = 5'($urandom_range(0, 31));
      data[i]  = $urandom;
    end
    for (int c = 0; c < 300; c++) begin
      init_req = ($urandom_range(0, 49) == 0);
      #1;
      exp_ready = model_ready();
      n_cmp++; if (ready !== exp_ready) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", c, ready, exp_ready); end
      model_clock();
      @(posedge clk); #1;
      n_cmp++; if (wr_en !== m_en || done !== m_done) begin
        n_err++; $display("FAIL rand_ctrl[%0d]: got en=%b done=%b want en=%b done=%b", c, wr_en, done, m_en, m_done);
      end
      if (m_en) begin
        n_cmp++; if (wr_addr !== m_addr || wr_data !== m_data) begin
          n_err++; $display("FAIL rand_write[%0d]: got addr=%0d data=%h want addr=%0d data=%h", c, wr_addr, wr_data, m_addr, m_data);
        end
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!valid[i] || exp_ready[i]) begin
          valid[i] = ($urandom_range(0, 9) < 6);
          addr[i]  = 5'($urandom_range(0, 31));
          data[i]  = $urandom;
        end
      end
    end
    init_req = 1'b0;
    valid    = 3'b000;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 12; k++) begin
      #1;
      model_clock();
      @(posedge clk); #1;
      if (k < 12) @(negedge clk);
    end
    n_cmp++; if (wr_addr !== 5'd12) begin n_err++; $display("FAIL mid_addr: got %0d want 12", wr_addr); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 || done !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_outputs: got en=%b addr=%0d data=%h done=%b want all 0", wr_en, wr_addr, wr_data, done);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    model_clock();
    @(posedge clk); #1;
    n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd1 || wr_data !== 32'd0) begin
      n_err++; $display("FAIL restart_write: got en=%b addr=%0d data=%h want en=1 addr=1 data=0", wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    init_req = 1'b0;
    valid    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      addr[i] = '0;
      data[i] = '0;
    end
    model_reset();

    test_reset();
    test_round_robin();
    test_x0_write();
    test_x9_write();
    test_init_req();
    test_random();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rv_rf_wr_ctrl.md
RV_RF_WR_CTRL -- requirements
Module: rv_rf_wr_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = CSR).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port init_req_i  input  1  single-cycle pulse requesting a re-clear of the register file.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester write request.
REQ-006 SHALL have port req_rd_addr_i  input  NUM_REQ x 5  per-requester destination register.
REQ-007 SHALL have port req_data_i  input  NUM_REQ x 32  per-requester write data.
REQ-008 SHALL have port req_ready_o  output  NUM_REQ  one-hot-or-zero grant; a transfer occurs when valid and ready are both high.
REQ-009 SHALL have port rf_wr_en_o  output  1  register file write enable.
REQ-010 SHALL have port rf_rd_addr_o  output  5  register file write address.
REQ-011 SHALL have port rf_wr_data_o  output  32  register file write data.
REQ-012 SHALL have port init_done_o  output  1  high while in RUN.

Function
REQ-013 SHALL implement a two-state FSM: INIT (sequential clear of x1..x31) and RUN (arbitrated writeback).
REQ-014 In INIT, each clock edge SHALL register rf_wr_en_o=1, rf_rd_addr_o=cnt, rf_wr_data_o=0, then increment cnt; cnt runs 1..31.
REQ-015 The edge that registers address 31 SHALL also move the FSM to RUN; the clear takes exactly 31 cycles.
REQ-016 In INIT, req_ready_o SHALL be all zero.
REQ-017 In RUN, req_ready_o SHALL be combinational: at most one bit set, selected round-robin among asserted req_valid_i.
REQ-018 Round-robin priority SHALL start at (last granted index + 1) mod NUM_REQ; the pointer updates only on a transfer.
REQ-019 A transfer in cycle N SHALL appear on rf_wr_en_o, rf_rd_addr_o and rf_wr_data_o after edge N+1 (one-cycle latency, registered outputs).
REQ-020 A transfer with rd address 0 SHALL be accepted (ready high), but rf_wr_en_o SHALL be 0 on the following cycle.
REQ-021 A cycle with no transfer SHALL register rf_wr_en_o=0; address and data SHALL hold their previous values.
REQ-022 Requesters hold valid, address and data until ready; the block SHALL NOT require valid to drop after a transfer (back-to-back transfers are allowed).
REQ-023 init_req_i high in RUN SHALL force req_ready_o to 0 in that cycle and enter INIT with cnt=1 at the next edge; init_req_i SHALL be ignored in INIT.
REQ-024 A transfer in the cycle before init_req_i SHALL still complete its write on the next edge.

Reset
REQ-025 Reset assertion SHALL immediately force: state=INIT, cnt=1, rr pointer=NUM_REQ-1 (requester 0 first), rf_wr_en_o=0, rf_rd_addr_o=0, rf_wr_data_o=0, init_done_o=0.
REQ-026 Reset asserted mid-INIT or mid-RUN SHALL abandon the operation in progress; the clear SHALL restart at x1 after reset deasserts.

Structure
REQ-027 Package rv_rf_pkg SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32, and the FSM state enum {INIT, RUN}.
REQ-028 The round-robin grant logic SHALL be a sub-module rv_rr_arb (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-029 Reset release -> 31 consecutive writes x1..x31 with data 0, ready all 0; init_done_o=1 after the 31st edge.
REQ-030 RUN, all three valid continuously with distinct addresses 5, 6, 7 -> grants in order 0, 1, 2, 0, ...; a write appears every cycle.
REQ-031 RUN, requester 1 writes x0 with data 0xDEADBEEF -> ready_o[1]=1, rf_wr_en_o=0 on the next cycle.
REQ-032 RUN, requester 2 writes x9 with data 0x12345678 -> next cycle rf_wr_en_o=1, rf_rd_addr_o=9, rf_wr_data_o=0x12345678.
REQ-033 init_req_i pulsed while requester 0 is valid -> no grant that cycle; 31 clear writes follow; requester 0 is granted in the first RUN cycle.
REQ-034 Reset asserted at clear address 12 -> outputs zero immediately; the clear restarts at x1 after release.
